uart_rx_param: RTL

Parametrised UART receive engine for the Minilab serial path, the successor to the fixed 8N1 receiver. It samples `rx` on an oversampled tick with 3-sample majority voting and configurable data width, parity and stop bits. It presents each received word with `valid`/`clr_valid` handshaking and reports parity, framing and overrun errors. It sits between the pad-side `rx` line and the register/SPART interface logic.

---
 rtl/uart_rx_param.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param -- parametrised UART receive engine.
//
// Samples the serial line on an oversampled tick, decides each bit by a
// 3-sample majority around mid-bit and delivers the received word with a
// sticky valid/acknowledge handshake plus parity, framing and overrun flags.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   os_tick      sample enable at OVERSAMPLE x baud
//   rx           asynchronous serial input, idle high
//   clr_valid    consumer acknowledge, clears valid and overrun
//   data_out     last received word (LSB first on the line)
//   valid        word available, sticky until clr_valid
//   parity_err   parity mismatch on the word in data_out
//   frame_err    a stop bit was sampled low on the word in data_out
//   overrun      a word completed while valid was still set, sticky
//   busy         frame in progress
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 os_tick,
  input  logic                 rx,
  input  logic                 clr_valid,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int M  = OVERSAMPLE / 2;

  localparam logic [TW-1:0] T_TOP = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] S_LO  = TW'(M - 1);
  localparam logic [TW-1:0] S_MID = TW'(M);
  localparam logic [TW-1:0] S_HI  = TW'(M + 1);

  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY_ODD != 0);
  localparam logic          HAS_PAR   = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic                 rx_meta_q, rxs_q;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           smp_q, smp_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 valid_q, valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  logic [TW-1:0] cur_tick;
  logic          wrap, decide, maj, detect, data_done, last_stop;
  logic          done, false_start;

  // Two-flop synchroniser, idles high so reset does not look like a start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

  // tick_cnt_q holds the in-bit index of the most recent tick; cur_tick is
  // the index of the tick being processed now (detection tick is index 0).
  always_comb begin
    cur_tick    = (tick_cnt_q == T_TOP) ? '0 : tick_cnt_q + TW'(1);
    wrap        = os_tick && (state_q != IDLE) && (cur_tick == '0);
    decide      = os_tick && (state_q != IDLE) && (cur_tick == S_HI);
    maj         = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs_q) | (smp_q[1] & rxs_q);
    detect      = (state_q == IDLE) && os_tick && !rxs_q;
    data_done   = (bit_idx_q == LAST_DATA);
    last_stop   = (bit_idx_q == LAST_STOP);
    done        = (state_q == STOP) && decide && last_stop;
    false_start = (state_q == START) && decide && maj;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (detect) state_d = START;
      START: begin
        if (false_start) state_d = IDLE;
        else if (wrap)   state_d = DATA;
      end
      DATA:   if (wrap && data_done) state_d = HAS_PAR ? PARITY : STOP;
      PARITY: if (wrap) state_d = STOP;
      STOP:   if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q != IDLE);
  end

  // Bit-level datapath: tick counting, sampling, shifting and error capture.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    smp_d      = smp_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    if (os_tick) begin
      if (state_q == IDLE) begin
        if (!rxs_q) begin
          tick_cnt_d = '0;
          bit_idx_d  = '0;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
        end
      end else begin
        tick_cnt_d = cur_tick;
        if (cur_tick == S_LO)  smp_d[0] = rxs_q;
        if (cur_tick == S_MID) smp_d[1] = rxs_q;
        if (state_q == DATA && wrap && data_done) bit_idx_d = '0;
        if (decide) begin
          unique case (state_q)
            DATA: begin
              shift_d   = {maj, shift_q[DATA_BITS-1:1]};
              bit_idx_d = bit_idx_q + BW'(1);
            end
            PARITY: perr_d = (maj != ((^shift_q) ^ ODD));
            STOP: begin
              if (!maj)       ferr_d    = 1'b1;
              if (!last_stop) bit_idx_d = bit_idx_q + BW'(1);
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Word delivery. The last stop bit is folded in directly so the flags
  // land on the same edge that the FSM returns to IDLE.
  always_comb begin
    data_out_d   = data_out_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    valid_d      = clr_valid ? 1'b0 : valid_q;
    overrun_d    = clr_valid ? 1'b0 : overrun_q;
    if (done) begin
      data_out_d   = shift_q;
      parity_err_d = perr_q;
      frame_err_d  = ferr_q | ~maj;
      valid_d      = 1'b1;
      if (valid_q && !clr_valid) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q   <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      smp_q        <= '1;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      data_out_q   <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      tick_cnt_q   <= tick_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      smp_q        <= smp_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      data_out_q   <= data_out_d;
      valid_q      <= valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data_out   = data_out_q;
  assign valid      = valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule
